mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
- Sequencer for a ROWS x COLS systolic array of mac_unit PEs (8-bit operands, 17-bit accumulators).
- Accepts a dot-product job of length k_len over a valid/ready command port.
- Clears the PE accumulators, then streams k_len operand addresses to the activation and weight buffers with per-row and per-column skew enables.
- Waits for the array to drain, then presents a result-ready handshake to the readout logic.

Parameters:
- WORD_SIZE, 8: operand width; informational only; sets the accumulator width 2*WORD_SIZE+1 used by the overflow check.
- ROWS, 4: PE rows; sets the activation skew depth.
- COLS, 4: PE columns; sets the weight skew depth.
- K_W, 8: width of k_len and of rd_addr.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  controller can accept a job
- k_len  in  K_W  dot-product length; sampled on cmd handshake
- mac_clr  out  1  drives PE rst (accumulator clear)
- rd_en  out  1  operand buffer read enable
- rd_addr  out  K_W  operand index; the same index goes to the A and W buffers
- row_en  out  ROWS  skewed activation inject enables
- col_en  out  COLS  skewed weight inject enables
- busy  out  1  high in every state except IDLE
- res_valid  out  1  array results are final
- res_ready  in  1  readout has consumed the results

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, mac_clr=1 (mac_clr = rst OR state==CLEAR), rd_en=0, rd_addr=0, row_en=0, col_en=0, busy=0, res_valid=0, cmd_ready=0 during rst.
- rst asserted at any point, including mid-FEED or mid-FLUSH, aborts the job. The skew shift registers are cleared and no res_valid is issued.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch k_len and go to CLEAR.
- CLEAR: exactly 1 cycle with mac_clr=1. Next state is FEED, or FLUSH if k_len==0 (the job then yields all-zero results).
- FEED: k_cnt runs 0..k_len-1. rd_en=1 and rd_addr=k_cnt. When k_cnt==k_len-1, go to FLUSH. rd_addr returns to 0 outside FEED.
- Skew: row_en[0]=col_en[0]=rd_en. row_en[r] is rd_en delayed r cycles; col_en[c] is rd_en delayed c cycles. Each enable is a registered delay line; it keeps shifting in FLUSH and is all zero by DONE.
- FLUSH: fcnt counts ROWS+COLS-1 cycles, covering skew plus the PE accumulate register. Then go to DONE.
- DONE: res_valid=1, held until res_ready. On res_valid&res_ready, return to IDLE; res_valid drops the next cycle.
- res_ready high outside DONE is ignored. cmd_valid outside IDLE is not accepted (cmd_ready=0).
- Latency from handshake cycle 0: CLEAR at cycle 1, FEED at 2..k_len+1, first res_valid at cycle k_len+ROWS+COLS+1. For k_len==0, res_valid is at cycle ROWS+COLS+1.
- k_len = 2^K_W-1 is legal. k_cnt is K_W bits and never wraps, because the FEED exit compare happens before the increment.
- Back-to-back jobs: after the DONE handshake, the earliest next cmd accept is the following cycle (in IDLE).

Optional Feature:
- Macro: MAC_ARRAY_CTRL_OVF_CHECK_EN.
- Defined:
  - Adds output port ovf_warn (1 bit, reset 0).
  - ovf_warn is registered high in CLEAR when latched k_len > MAX_SAFE_K (=2). At that length a 17-bit accumulator can overflow (3*255*255 > 2^17-1).
  - ovf_warn holds through DONE and clears on the DONE handshake or on rst.
  - The job still runs normally.
- Undefined: the port and its logic are absent; no length check is performed.

Decomposition:
- Package mac_ctrl_pkg holds:
  - state enum {IDLE, CLEAR, FEED, FLUSH, DONE}
  - localparam MAX_SAFE_K = 2
  - function flush_len(ROWS,COLS) = ROWS+COLS-1
- One sub-module, skew_line: a parameterized DEPTH-tap registered delay line with synchronous clear. It is instantiated once for row_en (DEPTH=ROWS) and once for col_en (DEPTH=COLS).

Test Plan (ROWS=COLS=4, K_W=8):
1. rst, then k_len=3 handshake at cycle 0:
   - mac_clr=1 at cycle 1.
   - rd_addr = 0,1,2 at cycles 2-4.
   - row_en[3] high at cycles 5-7.
   - res_valid rises at cycle 12.
   - res_ready=1 at 12 gives busy=0 at 13.
2. k_len=0: no rd_en pulses; res_valid at cycle 9; row_en and col_en stay 0.
3. Hold res_ready=0 for 5 cycles in DONE:
   - res_valid stays 1 and cmd_ready stays 0.
   - A cmd_valid pulse during DONE is not accepted.
4. Assert rst for 1 cycle during FEED (k_len=10, cycle 5):
   - Next cycle: state IDLE, rd_en=0, row_en/col_en=0, no res_valid afterwards.
5. k_len=255: rd_addr reaches 254 with no wrap; res_valid at cycle 255+9=264.
6. With MAC_ARRAY_CTRL_OVF_CHECK_EN:
   - k_len=2 gives ovf_warn=0.
   - k_len=3 gives ovf_warn=1 from cycle 2 until the DONE handshake.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the systolic-array MAC sequencer.
package mac_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      FLUSH,
      DONE
   } state_t;

   localparam int MAX_SAFE_K = 2;

   // Skew across the array plus the PE accumulate register.
   function automatic int flush_len(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

endpackage

// File: rtl/mac_array_ctrl_skew_line.sv
// skew_line: DEPTH-tap registered delay line; taps[i] is din delayed i cycles.
module skew_line #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             din,
   output logic [DEPTH-1:0] taps
);

   if (DEPTH > 1) begin : g_dly
      logic [DEPTH-2:0] dly;

      always_ff @(posedge clk) begin
         if (clr) begin
            dly <= '0;
         end else begin
            dly[0] <= din;
            for (int i = 1; i < DEPTH - 1; i++) begin
               dly[i] <= dly[i-1];
            end
         end
      end

      assign taps = clr ? '0 : {dly, din};
   end else begin : g_wire
      assign taps = clr ? 1'b0 : din;
   end

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: job sequencer for a ROWS x COLS systolic MAC array.
// Optional accumulator-overflow warning enabled by MAC_ARRAY_CTRL_OVF_CHECK_EN.
module mac_array_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int K_W       = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [K_W-1:0]  k_len,
   output logic            mac_clr,
   output logic            rd_en,
   output logic [K_W-1:0]  rd_addr,
   output logic [ROWS-1:0] row_en,
   output logic [COLS-1:0] col_en,
   output logic            busy,
   output logic            res_valid,
   input  logic            res_ready
`ifdef MAC_ARRAY_CTRL_OVF_CHECK_EN
   ,
   output logic            ovf_warn
`endif
);

   localparam int FLUSH_LEN = flush_len(ROWS, COLS);
   localparam int FW        = $clog2(FLUSH_LEN + 1);

   state_t         state, state_nxt;
   logic [K_W-1:0] k_len_q;
   logic [K_W-1:0] k_cnt;
   logic [FW-1:0]  fcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FEED exit is decided before k_cnt increments, so k_len = 2^K_W-1 never wraps.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_valid) state_nxt = CLEAR;
         CLEAR:   state_nxt = (k_len_q == '0) ? FLUSH : FEED;
         FEED:    if (k_cnt == k_len_q - K_W'(1)) state_nxt = FLUSH;
         FLUSH:   if (fcnt == FW'(FLUSH_LEN - 1)) state_nxt = DONE;
         DONE:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_len_q <= '0;
         k_cnt   <= '0;
         fcnt    <= '0;
      end else begin
         if (state == IDLE && cmd_valid) begin
            k_len_q <= k_len;
         end
         k_cnt <= (state == FEED && state_nxt == FEED) ? k_cnt + K_W'(1) : '0;
         fcnt  <= (state == FLUSH && state_nxt == FLUSH) ? fcnt + FW'(1) : '0;
      end
   end

   // Every handshake-facing output is forced quiet while rst is held.
   always_comb begin
      mac_clr   = rst || (state == CLEAR);
      cmd_ready = !rst && (state == IDLE);
      rd_en     = !rst && (state == FEED);
      rd_addr   = rd_en ? k_cnt : '0;
      busy      = !rst && (state != IDLE);
      res_valid = !rst && (state == DONE);
   end

   skew_line #(.DEPTH(ROWS)) u_row_skew (
      .clk  (clk),
      .clr  (rst),
      .din  (rd_en),
      .taps (row_en)
   );

   skew_line #(.DEPTH(COLS)) u_col_skew (
      .clk  (clk),
      .clr  (rst),
      .din  (rd_en),
      .taps (col_en)
   );

`ifdef MAC_ARRAY_CTRL_OVF_CHECK_EN
   // A (2*WORD_SIZE+1)-bit accumulator can overflow beyond MAX_SAFE_K products.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_warn <= 1'b0;
      end else if (state == CLEAR) begin
         ovf_warn <= (k_len_q > K_W'(MAX_SAFE_K));
      end else if (state == DONE && res_ready) begin
         ovf_warn <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: vector table, hand sequences and
// randomized traffic against a cycle-offset reference model.
module tb_mac_array_ctrl;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int K_W  = 8;
   localparam int DONE_OFS = ROWS + COLS + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [K_W-1:0]  k_len;
   logic            mac_clr;
   logic            rd_en;
   logic [K_W-1:0]  rd_addr;
   logic [ROWS-1:0] row_en;
   logic [COLS-1:0] col_en;
   logic            busy;
   logic            res_valid;
   logic            res_ready;
`ifdef MAC_ARRAY_CTRL_OVF_CHECK_EN
   logic            ovf_warn;
`endif

   mac_array_ctrl #(.WORD_SIZE(8), .ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .k_len     (k_len),
      .mac_clr   (mac_clr),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .row_en    (row_en),
      .col_en    (col_en),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready)
`ifdef MAC_ARRAY_CTRL_OVF_CHECK_EN
      ,
      .ovf_warn  (ovf_warn)
`endif
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: a job is just "cycles since the accept handshake".
   bit m_active = 1'b0;
   int m_rel    = 0;
   int m_k      = 0;
   bit sampled_valid;

   task automatic compareVal(input string name, input logic [31:0] act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit cv, input int k, input bit rr, input bit rs);
      cmd_valid = cv;
      k_len     = K_W'(k);
      res_ready = rr;
      rst       = rs;
   endtask

   task automatic checkOutput();
      int e_clr, e_rdy, e_rd, e_addr, e_busy, e_val, e_row, e_col;
      e_clr = 0; e_rdy = 0; e_rd = 0; e_addr = 0; e_busy = 0; e_val = 0; e_row = 0; e_col = 0;
      if (rst) begin
         e_clr = 1;
      end else if (!m_active) begin
         e_rdy = 1;
      end else begin
         e_clr  = (m_rel == 1);
         e_rd   = (m_rel >= 2 && m_rel <= m_k + 1);
         e_addr = e_rd ? m_rel - 2 : 0;
         e_busy = 1;
         e_val  = (m_rel >= m_k + DONE_OFS);
         for (int r = 0; r < ROWS; r++)
            if (m_rel >= 2 + r && m_rel <= m_k + 1 + r) e_row |= (1 << r);
         for (int c = 0; c < COLS; c++)
            if (m_rel >= 2 + c && m_rel <= m_k + 1 + c) e_col |= (1 << c);
      end
      compareVal("mac_clr", 32'(mac_clr), e_clr);
      compareVal("cmd_ready", 32'(cmd_ready), e_rdy);
      compareVal("rd_en", 32'(rd_en), e_rd);
      compareVal("rd_addr", 32'(rd_addr), e_addr);
      compareVal("row_en", 32'(row_en), e_row);
      compareVal("col_en", 32'(col_en), e_col);
      compareVal("busy", 32'(busy), e_busy);
      compareVal("res_valid", 32'(res_valid), e_val);
`ifdef MAC_ARRAY_CTRL_OVF_CHECK_EN
      if (!rst)
         compareVal("ovf_warn", 32'(ovf_warn), int'(m_active && m_rel >= 2 && m_k > 2));
`endif
      sampled_valid = (res_valid === 1'b1);
   endtask

   task automatic modelUpdate();
      if (rst) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (cmd_valid) begin
            m_active = 1'b1;
            m_rel    = 1;
            m_k      = int'(k_len);
         end
      end else if (m_rel >= m_k + DONE_OFS && res_ready) begin
         m_active = 1'b0;
      end else begin
         m_rel++;
      end
   endtask

   // One clock: check at the falling edge, advance the model on the rising edge.
   task automatic step();
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   typedef struct {
      int k;
      int wait_cycles;
      int exp_valid_cycle;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int  first;
      bit  seen;

      vecs[0] = '{k: 3,   wait_cycles: 0, exp_valid_cycle: 12};
      vecs[1] = '{k: 0,   wait_cycles: 0, exp_valid_cycle: 9};
      vecs[2] = '{k: 1,   wait_cycles: 5, exp_valid_cycle: 10};
      vecs[3] = '{k: 2,   wait_cycles: 0, exp_valid_cycle: 11};
      vecs[4] = '{k: 255, wait_cycles: 0, exp_valid_cycle: 264};
      vecs[5] = '{k: 7,   wait_cycles: 2, exp_valid_cycle: 16};

      applyStimulus(0, 0, 0, 1);
      step();
      step();

      foreach (vecs[i]) begin
         applyStimulus(1, vecs[i].k, 0, 0);
         step();
         first = -1;
         for (int c = 1; c <= 400; c++) begin
            applyStimulus(0, 0, 0, 0);
            step();
            if (sampled_valid) begin
               first = c;
               break;
            end
         end
         compareVal("res_valid_cycle", 32'(first), vecs[i].exp_valid_cycle);
         for (int w = 0; w < vecs[i].wait_cycles; w++) begin
            applyStimulus(w == 1, 5, 0, 0);
            step();
         end
         applyStimulus(0, 0, 1, 0);
         step();
         compareVal("busy_after_done", 32'(busy), 0);
         applyStimulus(0, 0, 0, 0);
         step();
      end

      // Abort a k_len=10 job with a single-cycle rst at cycle 5 (mid-FEED).
      applyStimulus(1, 10, 0, 0);
      step();
      for (int c = 1; c < 5; c++) begin
         applyStimulus(0, 0, 0, 0);
         step();
      end
      applyStimulus(0, 0, 0, 1);
      step();
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         applyStimulus(0, 0, c[0], 0);
         step();
         seen |= sampled_valid;
      end
      compareVal("no_res_valid_after_abort", 32'(seen), 0);

      // Randomized traffic, including back-to-back accepts and rare resets.
      for (int n = 0; n < 4000; n++) begin
         applyStimulus($urandom_range(0, 2) == 0,
                       ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12)),
                       $urandom_range(0, 1) == 1,
                       $urandom_range(0, 299) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
